// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface instr_encoder_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        fmt_i;
  logic [6:0]        opcode_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [XLEN-1:0]   imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_instr_o;
  logic [ADDR_W-1:0] out_addr_o;
  logic              out_err_o;

  modport master (
    output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
  );

  modport slave (
    input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into 32-bit words for a start/len job, tagging each word with its
// address; out-of-range fields are replaced by a NOP and counted.
module instr_encoder #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  instr_encoder_if.slave    bus,
  output logic [LEN_W-1:0]  err_cnt_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [LEN_W-1:0]  err_cnt_q, err_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;

  logic        in_ready, accept, drain;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        i_ok, b_ok, j_ok, u_ok;

  logic [XLEN-1:0] imm;
  assign imm = bus.imm_i;

  // Upper bits must be a pure sign extension of the encodable field.
  assign i_ok = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
  assign b_ok = ((&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12])) & ~imm[0];
  assign j_ok = ((&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20])) & ~imm[0];
  assign u_ok = ~(|imm[11:0]);

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (bus.fmt_i)
      3'd0: enc_instr = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i,
                         bus.opcode_i};
      3'd1: begin
        enc_instr = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
        enc_err   = ~i_ok;
      end
      3'd2: begin
        enc_instr = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.opcode_i};
        enc_err   = ~i_ok;
      end
      3'd3: begin
        enc_instr = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:1],
                     imm[11], bus.opcode_i};
        enc_err   = ~b_ok;
      end
      3'd4: begin
        enc_instr = {imm[31:12], bus.rd_i, bus.opcode_i};
        enc_err   = ~u_ok;
      end
      3'd5: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.opcode_i};
        enc_err   = ~j_ok;
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_instr = Nop;
  end

  assign in_ready = (state_q == StRun) && (acc_cnt_q < len_q) &&
                    (!out_valid_q || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;
  assign drain    = out_valid_q && bus.out_ready_i;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    out_cnt_d   = out_cnt_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d    = base_addr_i;
          len_d     = len_i;
          acc_cnt_d = '0;
          out_cnt_d = '0;
          err_cnt_d = '0;
          state_d   = (len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (drain) begin
          out_valid_d = 1'b0;
          out_cnt_d   = out_cnt_q + LEN_W'(1);
          if (out_cnt_q == len_q - LEN_W'(1)) state_d = StDone;
        end
        // An accept in the same cycle as a drain refills the register for full throughput.
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_instr;
          out_addr_d  = base_q + ADDR_W'({acc_cnt_q, 2'b00});
          out_err_d   = enc_err;
          acc_cnt_d   = acc_cnt_q + LEN_W'(1);
          if (enc_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + LEN_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      err_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      out_cnt_q   <= out_cnt_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_instr_o = out_instr_q;
  assign bus.out_addr_o  = out_addr_q;
  assign bus.out_err_o   = out_err_q;
  assign err_cnt_o       = err_cnt_q;
  assign busy_o          = (state_q == StRun);
  assign done_o          = (state_q == StDone);
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field bundles with hand-encoded expected words.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic [15:0] err_cnt_o;
  logic        busy_o;
  logic        done_o;

  instr_encoder_if #(.XLEN(32), .ADDR_W(32)) bus ();

  instr_encoder #(.XLEN(32), .ADDR_W(32), .LEN_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .bus         (bus),
    .err_cnt_o   (err_cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          recv = 0;
  int          done0, recv0;
  logic [31:0] exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the head of the scoreboard whenever a word is presented.
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (rst_n && bus.out_valid_o) begin
      if (sb_q.size() == 0) begin
        if (bus.out_ready_i) check("unexpected_beat", bus.out_instr_o, 32'hxxxx_xxxx);
      end else begin
        mon_e = sb_q[0];
        check("instr", bus.out_instr_o, mon_e.instr);
        check("addr", bus.out_addr_o, mon_e.addr);
        check("err", {31'd0, bus.out_err_o}, {31'd0, mon_e.err});
        if (bus.out_ready_i) begin
          void'(sb_q.pop_front());
          recv++;
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input logic [15:0] len);
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len;
    exp_addr    = base;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp,
                      input logic err);
    bit ok = 1'b0;
    bus.fmt_i = fmt; bus.opcode_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
    bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
    bus.in_valid_i = 1'b1;
    sb_q.push_back('{instr: exp, addr: exp_addr, err: err});
    exp_addr = exp_addr + 32'd4;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && done_cnt == done0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, done0 + 1);
    check("recv_beats", recv, recv0);
    check("queue_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.fmt_i = '0; bus.opcode_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rst_instr", bus.out_instr_o, 32'd0);
    check("rst_addr", bus.out_addr_o, 32'd0);
    check("rst_errcnt", {16'd0, err_cnt_o}, 32'd0);
    check("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Legal words of every format; unused fields carry junk that must not leak through.
    done0 = done_cnt; recv0 = recv + 7;
    start_job(32'h100, 16'd7);
    check("busy_run", {31'd0, busy_o}, 32'd1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7f, 32'd5, 32'h0050_0093, 1'b0);
    send(3'd2, 7'h23, 5'd9, 5'd0, 5'd2, 3'd2, 7'h55, 32'd8, 32'h0020_2423, 1'b0);
    send(3'd3, 7'h63, 5'd7, 5'd0, 5'd0, 3'd0, 7'h11, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd3, 5'd4, 3'd7, 7'h22, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd5, 7'h6f, 5'd1, 5'd9, 5'd9, 3'd5, 7'h33, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd17, 3'd0, 7'h44, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    wait_done();
    check("errcnt_clean", {16'd0, err_cnt_o}, 32'd0);

    // Range and format errors become NOPs and are counted.
    done0 = done_cnt; recv0 = recv + 4;
    start_job(32'h200, 16'd4);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h0000_0013, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0000_0013, 1'b1);
    send(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd6, 32'h0000_0363, 1'b0);
    wait_done();
    check("errcnt_three", {16'd0, err_cnt_o}, 32'd3);

    // Back-pressure mid-stream with an address that wraps past 2^32.
    done0 = done_cnt; recv0 = recv + 4;
    start_job(32'hFFFF_FFF8, 16'd4);
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i * 3),
               {12'(i * 3), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
      end
    join
    wait_done();

    // Empty job completes straight away.
    done0 = done_cnt;
    start_job(32'h400, 16'd0);
    @(negedge clk);
    check("len0_done", {31'd0, done_o}, 32'd1);
    check("len0_valid", {31'd0, bus.out_valid_o}, 32'd0);
    @(negedge clk);
    check("len0_done_drop", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;

    // Start while busy is ignored; reset mid-job aborts without done.
    start_job(32'h300, 16'd3);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 1'b0);
    start_i = 1'b1; base_addr_i = 32'h900; len_i = 16'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_kept", {31'd0, busy_o}, 32'd1);
    bus.out_ready_i = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, 32'h0070_0113, 1'b0);
    @(posedge clk); #1;
    done0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("abort_instr", bus.out_instr_o, 32'd0);
    check("abort_addr", bus.out_addr_o, 32'd0);
    check("abort_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, done0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
